// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, byte and halfword stores merged
// into the memory word by read-modify-write, with all outputs driven from registers.
module load_store_unit #(
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_load,
    output logic        dmem_store,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR, RESP} state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_q;

    logic        req_err;
    logic [31:0] word_idx;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        word_idx = {2'b00, req_addr[31:2]};
        req_err  = 1'b0;
        if (req_store) begin
            if (req_funct3[2] || req_funct3[1:0] == 2'b11) req_err = 1'b1;
        end else if (req_funct3 inside {3'b011, 3'b110, 3'b111}) begin
            req_err = 1'b1;
        end
        if (req_funct3[1:0] == 2'b01 && req_addr[0])          req_err = 1'b1;
        if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
        if (word_idx >= DMEM_WORDS)                              req_err = 1'b1;
    end

    // Lane extraction and merge work on the latched request and live read data.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    lane_b = dmem_rdata[7:0];
            2'd1:    lane_b = dmem_rdata[15:8];
            2'd2:    lane_b = dmem_rdata[23:16];
            default: lane_b = dmem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_val = {24'h0, lane_b};
            3'b101:  load_val = {16'h0, lane_h};
            default: load_val = dmem_rdata;
        endcase

        merged = dmem_rdata;
        if (funct3_q[0]) begin
            if (addr_q[1]) merged[31:16] = wdata_q;
            else           merged[15:0]  = wdata_q;
        end else begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dmem_load  <= 1'b0;
            dmem_store <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            funct3_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            // Every output is a one-state pulse; the case below only raises them.
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dmem_load  <= 1'b0;
            dmem_store <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        funct3_q  <= req_funct3;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata[15:0];
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (!req_store) begin
                            state     <= LD;
                            dmem_load <= 1'b1;
                            dmem_addr <= {req_addr[31:2], 2'b00};
                        end else if (req_funct3 == 3'b010) begin
                            state      <= ST;
                            dmem_store <= 1'b1;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_wdata <= req_wdata;
                        end else begin
                            state     <= RMW_RD;
                            dmem_load <= 1'b1;
                            dmem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                LD: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_val;
                end
                ST: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                RMW_RD: begin
                    state      <= RMW_WR;
                    dmem_store <= 1'b1;
                    dmem_addr  <= {addr_q[31:2], 2'b00};
                    dmem_wdata <= merged;
                end
                RMW_WR: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: word-addressed memory model, latency,
// lane extraction, read-modify-write merge, error, reset and back-to-back checks.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        dmem_load;
    logic        dmem_store;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    logic [31:0] mem [0:1023];

    int vectors     = 0;
    int miscompares = 0;
    int load_cnt    = 0;
    int store_cnt   = 0;
    int both_cnt    = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DMEM_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dmem_load  (dmem_load),
        .dmem_store (dmem_store),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata)
    );

    assign dmem_rdata = mem[dmem_addr[11:2]];

    always @(posedge clk) begin
        if (dmem_store) mem[dmem_addr[11:2]] <= dmem_wdata;
    end

    always @(negedge clk) begin
        if (dmem_load)  load_cnt++;
        if (dmem_store) store_cnt++;
        if (dmem_load && dmem_store) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE (called at posedge+1) and check the whole transaction.
    task automatic run_op(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_ld, input int exp_st);
        int lat;
        logic [31:0] rdata;
        logic err;
        load_cnt  = 0;
        store_cnt = 0;
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq({tag, ".busy"}, 32'(req_ready), 32'd0);
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata;
        err   = resp_err;
        check_eq({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, ".rdata"}, rdata, exp_rdata);
        check_eq({tag, ".err"}, 32'(err), 32'(exp_err));
        @(posedge clk); #1;
        check_eq({tag, ".ld"}, 32'(load_cnt), 32'(exp_ld));
        check_eq({tag, ".st"}, 32'(store_cnt), 32'(exp_st));
        check_eq({tag, ".idle"}, {29'd0, req_ready, resp_valid, resp_err}, 32'b100);
        check_eq({tag, ".rd0"}, resp_rdata, 32'd0);
    endtask

    logic [31:0] b2b_wd [0:1];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h40]  = 32'h8899AABB;
        mem[32'h41]  = 32'h11223344;
        mem[1023]    = 32'h5A5A0001;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.flags", {26'd0, req_ready, resp_valid, resp_err, dmem_load, dmem_store, 1'b0},
                 32'b100000);
        check_eq("rst.rdata", resp_rdata, 32'd0);
        check_eq("rst.daddr", dmem_addr, 32'd0);
        check_eq("rst.dwdata", dmem_wdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("lb101",  1'b0, 3'b000, 32'h101, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 1, 0);
        run_op("lbu101", 1'b0, 3'b100, 32'h101, 32'h0, 2, 32'h000000AA, 1'b0, 1, 0);
        run_op("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h00008899, 1'b0, 1, 0);
        run_op("lh102",  1'b0, 3'b001, 32'h102, 32'h0, 2, 32'hFFFF8899, 1'b0, 1, 0);
        run_op("lw100",  1'b0, 3'b010, 32'h100, 32'h0, 2, 32'h8899AABB, 1'b0, 1, 0);
        run_op("lh100",  1'b0, 3'b001, 32'h100, 32'h0, 2, 32'hFFFFAABB, 1'b0, 1, 0);
        run_op("lb103",  1'b0, 3'b000, 32'h103, 32'h0, 2, 32'hFFFFFF88, 1'b0, 1, 0);
        run_op("lbu100", 1'b0, 3'b100, 32'h100, 32'h0, 2, 32'h000000BB, 1'b0, 1, 0);
        run_op("lwtop",  1'b0, 3'b010, 32'hFFC, 32'h0, 2, 32'h5A5A0001, 1'b0, 1, 0);

        run_op("sb103", 1'b1, 3'b000, 32'h103, 32'h12345677, 3, 32'h0, 1'b0, 1, 1);
        check_eq("sb103.mem", mem[32'h40], 32'h7799AABB);
        run_op("sh106", 1'b1, 3'b001, 32'h106, 32'hCAFE1234, 3, 32'h0, 1'b0, 1, 1);
        check_eq("sh106.mem", mem[32'h41], 32'h12343344);
        run_op("sw108", 1'b1, 3'b010, 32'h108, 32'hDEADBEEF, 2, 32'h0, 1'b0, 0, 1);
        check_eq("sw108.mem", mem[32'h42], 32'hDEADBEEF);

        run_op("e.sh101", 1'b1, 3'b001, 32'h101,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        run_op("e.lw102", 1'b0, 3'b010, 32'h102,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        run_op("e.f3011", 1'b0, 3'b011, 32'h100,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        run_op("e.oor",   1'b0, 3'b010, 32'h1000, 32'h0, 1, 32'h0, 1'b1, 0, 0);
        run_op("e.s100",  1'b1, 3'b100, 32'h100,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        run_op("e.lh103", 1'b0, 3'b001, 32'h103,  32'h0, 1, 32'h0, 1'b1, 0, 0);
        check_eq("e.memkeep", mem[32'h40], 32'h7799AABB);

        // Reset during RMW_RD of an SB abandons the store.
        load_cnt = 0; store_cnt = 0;
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h100; req_wdata = 32'h000000FF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rmw.rd", 32'(dmem_load), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rmw.rdy", {30'd0, req_ready, resp_valid}, 32'b10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("rmw.quiet%0d", i), {30'd0, resp_valid, dmem_store}, 32'd0);
        end
        check_eq("rmw.st", 32'(store_cnt), 32'd0);
        check_eq("rmw.mem", mem[32'h40], 32'h7799AABB);

        // Reset wins over a simultaneous request.
        load_cnt = 0;
        rst = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0;
        check_eq("rstpri.rdy", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rstpri.ld", 32'(load_cnt), 32'd0);
        check_eq("rstpri.rv", 32'(resp_valid), 32'd0);

        // Continuous req_valid, alternating SW/LW; junk on the inputs while busy.
        b2b_wd[0] = 32'hA5A50F0F;
        b2b_wd[1] = 32'h13579BDF;
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_store  = (i % 2 == 0);
            req_funct3 = 3'b010;
            req_addr   = 32'h200;
            req_wdata  = (i % 2 == 0) ? b2b_wd[i / 2] : 32'h0;
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d.rdy0", i), 32'(req_ready), 32'd0);
            req_store = ~req_store; req_addr = 32'h3; req_funct3 = 3'b001; req_wdata = '1;
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d.rdy1", i), {30'd0, req_ready, resp_valid}, 32'b01);
            check_eq($sformatf("b2b%0d.rdata", i), resp_rdata, (i % 2 == 1) ? b2b_wd[i / 2] : 32'h0);
            check_eq($sformatf("b2b%0d.err", i), 32'(resp_err), 32'd0);
            @(posedge clk); #1;
            check_eq($sformatf("b2b%0d.rdy2", i), {30'd0, req_ready, resp_valid}, 32'b10);
        end
        req_valid = 1'b0;
        check_eq("b2b.mem", mem[32'h80], 32'h13579BDF);
        check_eq("nevboth", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
